// File: rtl/cylon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cylon_pkg
// Description : Shared constants and types for the cylon button front end.
//               Button channel indices and the auto-repeat FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package cylon_pkg;

    // Channel index of each physical push-button within the button vectors
    localparam int BTN_C = 0;
    localparam int BTN_L = 1;
    localparam int BTN_R = 2;

    // Auto-repeat state machine encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_t;

endpackage : cylon_pkg
`default_nettype wire

// File: rtl/button_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner_if
// Description : Bundle of raw button pins and the conditioned button outputs.
//               The master side drives the raw pins and consumes the
//               conditioned signals; the slave side is the conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
interface button_conditioner_if #(
    parameter int NUM_BUTTONS = 3
);
    logic [NUM_BUTTONS-1:0] btn_raw;
    logic [NUM_BUTTONS-1:0] btn_level;
    logic [NUM_BUTTONS-1:0] btn_press;
    logic [NUM_BUTTONS-1:0] btn_release;
    logic [NUM_BUTTONS-1:0] btn_repeat;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_repeat
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_repeat
    );
endinterface : button_conditioner_if
`default_nettype wire

// File: rtl/button_debounce_cell.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce_cell
// Description : One button channel: two-flop synchroniser, debounce counter,
//               registered press/release pulses and an auto-repeat FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debounce_cell
    import cylon_pkg::*;
#(
    parameter int DEBOUNCE_CLKS = 1_000_000,
    parameter int HOLD_CLKS     = 50_000_000,
    parameter int REPEAT_CLKS   = 10_000_000
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_btn_raw,
    output logic      o_btn_level,
    output logic      o_btn_press,
    output logic      o_btn_release,
    output logic      o_btn_repeat
);

    localparam int c_DEB_W   = $clog2(DEBOUNCE_CLKS + 1);
    localparam int c_RPT_MAX = (HOLD_CLKS > REPEAT_CLKS) ? HOLD_CLKS : REPEAT_CLKS;
    localparam int c_RPT_W   = $clog2(c_RPT_MAX + 1);
    localparam bit c_RPT_EN  = (HOLD_CLKS > 0);

    // Terminal counts; the counters restart from 0 so the last value is N-1
    localparam logic [c_DEB_W-1:0] c_DEB_LAST  = c_DEB_W'(DEBOUNCE_CLKS - 1);
    localparam logic [c_RPT_W-1:0] c_HOLD_LAST = c_RPT_W'((HOLD_CLKS > 0) ? HOLD_CLKS - 1 : 0);
    localparam logic [c_RPT_W-1:0] c_RPT_LAST  = c_RPT_W'(REPEAT_CLKS - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic [c_DEB_W-1:0] r_deb_cnt;
    logic               r_level;
    logic               r_press;
    logic               r_release;

    rpt_state_t         r_state;
    rpt_state_t         w_state_nxt;
    logic [c_RPT_W-1:0] r_rpt_cnt;
    logic [c_RPT_W-1:0] w_rpt_cnt_nxt;
    logic               r_repeat;
    logic               w_repeat_nxt;

    logic w_diff;
    logic w_toggle;
    logic w_press_evt;
    logic w_release_evt;

    // The level flips on the edge where a stable difference has lasted long enough
    assign w_diff        = (r_sync2 != r_level);
    assign w_toggle      = w_diff && (r_deb_cnt == c_DEB_LAST);
    assign w_press_evt   = w_toggle && !r_level;
    assign w_release_evt = w_toggle &&  r_level;

    // Two-flop synchroniser for the asynchronous pin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce counter, accepted level and the edge pulses that go with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deb_cnt <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= w_press_evt;
            r_release <= w_release_evt;
            if (!w_diff) begin
                r_deb_cnt <= '0;
            end else if (w_toggle) begin
                r_deb_cnt <= '0;
                r_level   <= ~r_level;
            end else begin
                r_deb_cnt <= r_deb_cnt + 1'b1;
            end
        end
    end

    // Repeat FSM state, counter and registered repeat pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_rpt_cnt <= '0;
            r_repeat  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rpt_cnt <= w_rpt_cnt_nxt;
            r_repeat  <= w_repeat_nxt;
        end
    end

    // Repeat FSM next state; a release always wins over a due repeat
    always_comb begin
        w_state_nxt   = r_state;
        w_rpt_cnt_nxt = r_rpt_cnt;
        w_repeat_nxt  = 1'b0;
        if (w_release_evt) begin
            w_state_nxt   = ST_IDLE;
            w_rpt_cnt_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_press_evt && c_RPT_EN) begin
                        w_state_nxt   = ST_HOLD;
                        w_rpt_cnt_nxt = '0;
                    end
                end
                ST_HOLD: begin
                    if (r_rpt_cnt == c_HOLD_LAST) begin
                        w_repeat_nxt  = 1'b1;
                        w_state_nxt   = ST_REPEAT;
                        w_rpt_cnt_nxt = '0;
                    end else begin
                        w_rpt_cnt_nxt = r_rpt_cnt + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (r_rpt_cnt == c_RPT_LAST) begin
                        w_repeat_nxt  = 1'b1;
                        w_rpt_cnt_nxt = '0;
                    end else begin
                        w_rpt_cnt_nxt = r_rpt_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt   = ST_IDLE;
                    w_rpt_cnt_nxt = '0;
                end
            endcase
        end
    end

    assign o_btn_level   = r_level;
    assign o_btn_press   = r_press;
    assign o_btn_release = r_release;
    assign o_btn_repeat  = r_repeat;

endmodule : button_debounce_cell
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Conditions NUM_BUTTONS raw push-buttons into debounced levels,
//               press/release pulses and auto-repeat pulses, one independent
//               cell per channel.
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner
    import cylon_pkg::*;
#(
    parameter int NUM_BUTTONS   = 3,
    parameter int DEBOUNCE_CLKS = 1_000_000,
    parameter int HOLD_CLKS     = 50_000_000,
    parameter int REPEAT_CLKS   = 10_000_000
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    button_conditioner_if.slave  btn_if
);

    // Reject parameter values the counters cannot represent
    if (DEBOUNCE_CLKS < 1) begin : g_chk_debounce
        $error("button_conditioner: DEBOUNCE_CLKS must be >= 1");
    end
    if (REPEAT_CLKS < 1) begin : g_chk_repeat
        $error("button_conditioner: REPEAT_CLKS must be >= 1");
    end
    if (HOLD_CLKS < 0) begin : g_chk_hold
        $error("button_conditioner: HOLD_CLKS must be >= 0");
    end

    logic [NUM_BUTTONS-1:0] w_level;
    logic [NUM_BUTTONS-1:0] w_press;
    logic [NUM_BUTTONS-1:0] w_release;
    logic [NUM_BUTTONS-1:0] w_repeat;

    // One fully independent conditioning cell per button
    for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_cell
        button_debounce_cell #(
            .DEBOUNCE_CLKS (DEBOUNCE_CLKS),
            .HOLD_CLKS     (HOLD_CLKS),
            .REPEAT_CLKS   (REPEAT_CLKS)
        ) u_cell (
            .clk           (clk),
            .rst_n         (rst_n),
            .i_btn_raw     (btn_if.btn_raw[gi]),
            .o_btn_level   (w_level[gi]),
            .o_btn_press   (w_press[gi]),
            .o_btn_release (w_release[gi]),
            .o_btn_repeat  (w_repeat[gi])
        );
    end

    assign btn_if.btn_level   = w_level;
    assign btn_if.btn_press   = w_press;
    assign btn_if.btn_release = w_release;
    assign btn_if.btn_repeat  = w_repeat;

endmodule : button_conditioner
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_conditioner
// Description : Scoreboard bench for button_conditioner. Each stimulus step
//               pushes the pulses it should cause (cycle, kind, channel);
//               a negedge monitor pops them and compares against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;
    import cylon_pkg::*;

    localparam int c_NB   = 3;
    localparam int c_DEB  = 4;
    localparam int c_HOLD = 10;
    localparam int c_RPT  = 5;
    // Raw change driven at the negedge of cycle d: sync at d+1, d+2, level at d+2+DEB
    localparam int c_LAT  = c_DEB + 2;

    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_REPEAT  = 2;

    typedef struct {
        int cyc;
        int kind;
        int ch;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    button_conditioner_if #(.NUM_BUTTONS(c_NB)) btn_if ();

    button_conditioner #(
        .NUM_BUTTONS   (c_NB),
        .DEBOUNCE_CLKS (c_DEB),
        .HOLD_CLKS     (c_HOLD),
        .REPEAT_CLKS   (c_RPT)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_if (btn_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic expect_evt(input int c, input int kind, input int ch);
        exp_t e;
        e.cyc  = c;
        e.kind = kind;
        e.ch   = ch;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Pop every expectation due this cycle and compare all three pulse vectors
    always @(negedge clk) begin : mon
        logic [c_NB-1:0] ep;
        logic [c_NB-1:0] er;
        logic [c_NB-1:0] et;
        ep = '0;
        er = '0;
        et = '0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                case (sb[i].kind)
                    K_PRESS:   ep[sb[i].ch] = 1'b1;
                    K_RELEASE: er[sb[i].ch] = 1'b1;
                    default:   et[sb[i].ch] = 1'b1;
                endcase
                sb.delete(i);
            end
        end
        if (ep != 0 || btn_if.btn_press != 0)   check("press",   btn_if.btn_press,   ep);
        if (er != 0 || btn_if.btn_release != 0) check("release", btn_if.btn_release, er);
        if (et != 0 || btn_if.btn_repeat != 0)  check("repeat",  btn_if.btn_repeat,  et);
    end

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : stim
        int c;
        int p;
        btn_if.btn_raw = 3'b111;
        rst_n = 1'b0;

        // Reset held with all buttons pressed: everything stays low
        repeat (3) @(negedge clk);
        check("rst_level",   btn_if.btn_level,   3'b000);
        check("rst_press",   btn_if.btn_press,   3'b000);
        check("rst_release", btn_if.btn_release, 3'b000);
        check("rst_repeat",  btn_if.btn_repeat,  3'b000);

        // Reset release with buttons still held: press on all channels at edge 6
        rst_n = 1'b1;
        c = cyc;
        for (int i = 0; i < c_NB; i++) expect_evt(c + 6, K_PRESS, i);
        wait_cyc(c + 5);
        check("rst_level_pre", btn_if.btn_level, 3'b000);
        wait_cyc(c + 6);
        check("rst_level_post", btn_if.btn_level, 3'b111);
        wait_cyc(c + 8);
        btn_if.btn_raw = 3'b000;
        for (int i = 0; i < c_NB; i++) expect_evt(c + 8 + c_LAT, K_RELEASE, i);
        wait_cyc(c + 8 + c_LAT);
        check("rst_level_off", btn_if.btn_level, 3'b000);
        wait_cyc(cyc + 10);

        // Clean press on C only
        c = cyc;
        btn_if.btn_raw[BTN_C] = 1'b1;
        expect_evt(c + c_LAT, K_PRESS, BTN_C);
        wait_cyc(c + c_LAT);
        check("clean_level", btn_if.btn_level, 3'b001);
        wait_cyc(c + 8);
        btn_if.btn_raw[BTN_C] = 1'b0;
        expect_evt(c + 8 + c_LAT, K_RELEASE, BTN_C);
        wait_cyc(c + 30);

        // Bounce on L: 1,0,1,0 for 3 cycles each, then held high
        c = cyc;
        for (int i = 0; i < 4; i++) begin
            btn_if.btn_raw[BTN_L] = ~i[0];
            wait_cyc(c + 3 * (i + 1));
        end
        check("bounce_level", btn_if.btn_level, 3'b000);
        btn_if.btn_raw[BTN_L] = 1'b1;
        expect_evt(c + 12 + c_LAT, K_PRESS, BTN_L);
        wait_cyc(c + 12 + c_LAT);
        check("bounce_level_on", btn_if.btn_level, 3'b010);
        wait_cyc(c + 20);
        btn_if.btn_raw[BTN_L] = 1'b0;
        expect_evt(c + 20 + c_LAT, K_RELEASE, BTN_L);
        wait_cyc(c + 40);

        // Auto-repeat on R: six repeats, then release before the seventh
        c = cyc;
        p = c + c_LAT;
        btn_if.btn_raw[BTN_R] = 1'b1;
        expect_evt(p, K_PRESS, BTN_R);
        for (int j = 0; j < 6; j++) expect_evt(p + c_HOLD + j * c_RPT, K_REPEAT, BTN_R);
        wait_cyc(p + 1);
        check("rpt_level", btn_if.btn_level, 3'b100);
        wait_cyc(p + 32);
        btn_if.btn_raw[BTN_R] = 1'b0;
        expect_evt(p + 32 + c_LAT, K_RELEASE, BTN_R);
        wait_cyc(p + 32 + c_LAT);
        check("rpt_level_off", btn_if.btn_level, 3'b000);
        wait_cyc(p + 60);

        // Release lands on the edge where the third repeat would fire
        c = cyc;
        p = c + c_LAT;
        btn_if.btn_raw[BTN_C] = 1'b1;
        expect_evt(p, K_PRESS, BTN_C);
        expect_evt(p + c_HOLD, K_REPEAT, BTN_C);
        expect_evt(p + c_HOLD + c_RPT, K_REPEAT, BTN_C);
        wait_cyc(p + c_HOLD + 2 * c_RPT - c_LAT);
        btn_if.btn_raw[BTN_C] = 1'b0;
        expect_evt(p + c_HOLD + 2 * c_RPT, K_RELEASE, BTN_C);
        wait_cyc(p + 50);

        // Reset asserted in REPEAT with L held, then released with L still held
        c = cyc;
        p = c + c_LAT;
        btn_if.btn_raw[BTN_L] = 1'b1;
        expect_evt(p, K_PRESS, BTN_L);
        expect_evt(p + c_HOLD, K_REPEAT, BTN_L);
        expect_evt(p + c_HOLD + c_RPT, K_REPEAT, BTN_L);
        wait_cyc(p + 17);
        check("mid_level_before", btn_if.btn_level, 3'b010);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_level",  btn_if.btn_level,  3'b000);
        check("mid_rst_repeat", btn_if.btn_repeat, 3'b000);
        repeat (3) @(negedge clk);
        check("mid_rst_level_hold", btn_if.btn_level, 3'b000);
        rst_n = 1'b1;
        c = cyc;
        expect_evt(c + c_LAT, K_PRESS, BTN_L);
        wait_cyc(c + c_LAT);
        check("mid_rst_repress", btn_if.btn_level, 3'b010);
        wait_cyc(c + 8);
        btn_if.btn_raw[BTN_L] = 1'b0;
        expect_evt(c + 8 + c_LAT, K_RELEASE, BTN_L);
        wait_cyc(c + 30);

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_button_conditioner
`default_nettype wire

// File: doc/button_conditioner.md
# button_conditioner

Conditions the raw push-buttons (centre, left, right) before they reach the LED-pattern mode logic. Each input is synchronised, debounced and turned into a clean level, a one-cycle press pulse, a one-cycle release pulse and an optional auto-repeat pulse. The mode-select logic of the cylon display consumes `btn_press` instead of raw `btnC/btnL/btnR`, so every physical press changes mode exactly once.

## Interface
Parameters:
- `NUM_BUTTONS`, 3: number of independent button channels. Bit 0 is C, bit 1 is L, bit 2 is R.
- `DEBOUNCE_CLKS`, 1_000_000: cycles the synchronised input must stay unchanged before it is accepted (10 ms at 100 MHz). Must be ≥ 1.
- `HOLD_CLKS`, 50_000_000: cycles from `btn_press` to the first `btn_repeat`. 0 disables repeat.
- `REPEAT_CLKS`, 10_000_000: cycles between later `btn_repeat` pulses. Must be ≥ 1.

Ports:
- `clk`, in, 1: the single clock. All logic is on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `btn_raw`, in, NUM_BUTTONS: raw asynchronous button pins, active-high.
- `btn_level`, out, NUM_BUTTONS: debounced button state.
- `btn_press`, out, NUM_BUTTONS: one-cycle pulse when `btn_level` rises.
- `btn_release`, out, NUM_BUTTONS: one-cycle pulse when `btn_level` falls.
- `btn_repeat`, out, NUM_BUTTONS: one-cycle auto-repeat pulse while a button is held.

## Operation
Each channel is fully independent. The per-channel pipeline is:
- **Synchroniser:** two flops, `sync1` then `sync2`.
- **Debounce counter** (width `$clog2(DEBOUNCE_CLKS+1)`):
  - cleared whenever `sync2 == btn_level`;
  - otherwise incremented;
  - on the edge where it equals `DEBOUNCE_CLKS-1` while `sync2 != btn_level`: `btn_level` toggles and the counter clears.
  - Any reversion of `sync2` before that edge clears the counter, so glitches shorter than `DEBOUNCE_CLKS` cycles never reach `btn_level`.
- **Edge pulses:** `btn_press` and `btn_release` are registered on the same edge that updates `btn_level`. Both are high for exactly one cycle.
- **Repeat state machine:** states IDLE, HOLD, REPEAT.
  - IDLE → HOLD on press, when `HOLD_CLKS` > 0. The repeat counter loads 0.
  - In HOLD, after `HOLD_CLKS` cycles: pulse `btn_repeat`, go to REPEAT, clear the counter.
  - In REPEAT, every `REPEAT_CLKS` cycles: pulse `btn_repeat`.
  - Any state → IDLE on release, counter cleared. A `btn_repeat` never coincides with `btn_release`; the release wins.
- The repeat counter is sized to `$clog2(max(HOLD_CLKS,REPEAT_CLKS)+1)`. It is never allowed to wrap.
- **Reset values:** `sync1`, `sync2`, `btn_level`, all pulses and all counters are 0; FSM state is IDLE.
- **Reset mid-press:** after `rst_n` rises with the button still held, the press is reported again as a fresh `btn_press` after the normal latency.

## Timing
- Raw input changes before edge k and then holds:
  - `sync2` reflects it after edge k+1;
  - `btn_level` and the press/release pulse update at edge k+1+`DEBOUNCE_CLKS`.
- First `btn_repeat` is high in the cycle after edge P+`HOLD_CLKS`, where P is the edge that raised `btn_press`. Later repeats follow at spacing `REPEAT_CLKS`.
- No combinational path from any input to any output. All outputs are registered.
- Simultaneous presses on several channels produce simultaneous pulses. No priority is applied here; prioritisation belongs to the consumer.

## Structure
- Shared package `cylon_pkg` holds:
  - the button index constants `BTN_C=0`, `BTN_L=1`, `BTN_R=2`;
  - the repeat FSM state enum (IDLE/HOLD/REPEAT).
- Natural sub-module: `button_debounce_cell`, a single channel (synchroniser, debounce counter, pulse and repeat logic). The top generates `NUM_BUTTONS` instances.
- Elaboration-time assertions reject `DEBOUNCE_CLKS` = 0 and `REPEAT_CLKS` = 0.

## Test plan
All scenarios use `DEBOUNCE_CLKS`=4, `HOLD_CLKS`=10, `REPEAT_CLKS`=5.
- **Reset:** hold `rst_n`=0 with `btn_raw`=3'b111 → all outputs 0. Release reset with the inputs still high → `btn_press`=3'b111 for one cycle at edge 6 after reset release.
- **Clean press:** `btn_raw[0]` goes 0→1 before edge 0 and holds → `btn_level[0]` rises and `btn_press[0]` pulses at edge 5. Nothing occurs on bits 1 and 2.
- **Bounce rejection:** `btn_raw[1]` toggles 1,0,1,0 with each value held 3 cycles, then holds 1 → exactly one `btn_press[1]`, 5 edges after the final rising edge is sampled. No release pulse.
- **Auto-repeat:** hold `btn_raw[2]` for 40 cycles after its press → `btn_repeat[2]` at P+10, P+15, P+20, P+25, P+30, P+35. Release → one `btn_release[2]` and no further repeats.
- **Release/repeat collision:** time the release so `btn_level` falls on the edge a repeat was due → only `btn_release` pulses. FSM is IDLE.
- **Reset mid-hold:** assert `rst_n`=0 during REPEAT → outputs clear immediately (asynchronous), and no pulse occurs on the same edge as reset release.
